// File: rtl/tree_accumulator.sv
// -----------------------------------------------------------------------------
// tree_accumulator
//
// Sums eight unsigned 8-bit lanes per beat through a three-stage registered
// adder tree. Each frame's beat totals are accumulated into a 16-bit running
// sum. A frame starts on the first valid beat seen in IDLE and ends on the
// first cycle in which in_valid is low. Once the adder pipeline has drained,
// done pulses for one cycle and sum holds the final frame total.
//
// Optional feature (compile-time macro TREE_ACC_AVG_EN):
//   defined   : avg = (sum + 128) >> 8, which is the rounded per-frame mean
//               over 256 lane-samples. It is combinational from the
//               registered sum.
//   undefined : avg is tied to zero and no rounding adder is built.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous active-high reset
//   in_valid  in   1   beat qualifier for in0..in7
//   in0..in7  in   8   unsigned lane samples
//   sum       out  16  registered frame total
//   done      out  1   one-cycle pulse; sum is final
//   ovf       out  1   sticky; the frame offered more than MAX_BEATS beats
//   avg       out  8   rounded mean (zero unless TREE_ACC_AVG_EN)
//
// Parameter:
//   MAX_BEATS  beats accepted per frame (1..63, default 32)
// -----------------------------------------------------------------------------
module tree_accumulator #(
    parameter int MAX_BEATS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in0,
    input  logic [7:0]  in1,
    input  logic [7:0]  in2,
    input  logic [7:0]  in3,
    input  logic [7:0]  in4,
    input  logic [7:0]  in5,
    input  logic [7:0]  in6,
    input  logic [7:0]  in7,
    output logic [15:0] sum,
    output logic        done,
    output logic        ovf,
    output logic [7:0]  avg
);

    localparam logic [5:0] MAX_CNT = 6'(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  beat_cnt_q, beat_cnt_d;
    logic        accept_s;
    logic        start_s;
    logic        drop_s;

    logic [8:0]  s1_q [4];
    logic        s1_vld_q;
    logic [9:0]  s2_q [2];
    logic        s2_vld_q;
    logic [10:0] s3_q;
    logic        s3_vld_q;

    logic [15:0] sum_q, sum_d;
    logic        ovf_q, ovf_d;
    logic        done_q;

    // Next-state logic, plus beat acceptance, frame start and overflow-drop decisions
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        accept_s   = 1'b0;
        start_s    = 1'b0;
        drop_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    start_s    = 1'b1;
                    accept_s   = 1'b1;
                    beat_cnt_d = 6'd1;
                    state_d    = FILL;
                end else begin
                    state_d    = IDLE;
                end
            end
            FILL: begin
                if (!in_valid) begin
                    state_d = DRAIN;
                end else if (beat_cnt_q < MAX_CNT) begin
                    accept_s   = 1'b1;
                    beat_cnt_d = beat_cnt_q + 6'd1;
                end else begin
                    // Counter saturates; excess beats are discarded and flagged.
                    drop_s = 1'b1;
                end
            end
            DRAIN: begin
                // Stage 3 is consumed at this same edge. Once stages 1 and 2
                // are empty, the final beat lands in sum as DONE is entered.
                if (!s1_vld_q && !s2_vld_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Accumulator and sticky overflow next values
    always_comb begin
        sum_d = sum_q;
        ovf_d = ovf_q;
        if (start_s) begin
            sum_d = 16'd0;
            ovf_d = 1'b0;
        end else begin
            if (s3_vld_q) begin
                sum_d = sum_q + {5'd0, s3_q};
            end else begin
                sum_d = sum_q;
            end
            if (drop_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // FSM state, beat counter, accumulator, flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= 6'd0;
            sum_q      <= 16'd0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            sum_q      <= sum_d;
            ovf_q      <= ovf_d;
            done_q     <= (state_d == DONE);
        end
    end

    // Three-stage adder tree with a valid tag travelling beside the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q[0]  <= 9'd0;
            s1_q[1]  <= 9'd0;
            s1_q[2]  <= 9'd0;
            s1_q[3]  <= 9'd0;
            s1_vld_q <= 1'b0;
            s2_q[0]  <= 10'd0;
            s2_q[1]  <= 10'd0;
            s2_vld_q <= 1'b0;
            s3_q     <= 11'd0;
            s3_vld_q <= 1'b0;
        end else begin
            s1_q[0]  <= {1'b0, in0} + {1'b0, in1};
            s1_q[1]  <= {1'b0, in2} + {1'b0, in3};
            s1_q[2]  <= {1'b0, in4} + {1'b0, in5};
            s1_q[3]  <= {1'b0, in6} + {1'b0, in7};
            s1_vld_q <= accept_s;
            s2_q[0]  <= {1'b0, s1_q[0]} + {1'b0, s1_q[1]};
            s2_q[1]  <= {1'b0, s1_q[2]} + {1'b0, s1_q[3]};
            s2_vld_q <= s1_vld_q;
            s3_q     <= {1'b0, s2_q[0]} + {1'b0, s2_q[1]};
            s3_vld_q <= s2_vld_q;
        end
    end

    assign sum  = sum_q;
    assign ovf  = ovf_q;
    assign done = done_q;

`ifdef TREE_ACC_AVG_EN
    // 17-bit add, so sum values near full scale cannot wrap before the shift.
    assign avg = 8'(({1'b0, sum_q} + 17'd128) >> 8);
`else
    assign avg = 8'd0;
`endif

endmodule

// File: tb/tb_tree_accumulator.sv
// -----------------------------------------------------------------------------
// tb_tree_accumulator
//
// Self-checking bench for tree_accumulator. It drives directed and random
// frames. The expected totals come from plain arithmetic over the lane values
// that were offered, counting only the first MAX beats of each frame.
// -----------------------------------------------------------------------------
module tb_tree_accumulator;

    localparam int MAX = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  lanes [8];
    logic [15:0] sum;
    logic        done;
    logic        ovf;
    logic [7:0]  avg;

    int checks   = 0;
    int failures = 0;

    tree_accumulator #(.MAX_BEATS(MAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in0      (lanes[0]),
        .in1      (lanes[1]),
        .in2      (lanes[2]),
        .in3      (lanes[3]),
        .in4      (lanes[4]),
        .in5      (lanes[5]),
        .in6      (lanes[6]),
        .in7      (lanes[7]),
        .sum      (sum),
        .done     (done),
        .ovf      (ovf),
        .avg      (avg)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_avg(input int s);
`ifdef TREE_ACC_AVG_EN
        return ((s + 128) >> 8) & 255;
`else
        return 0 * s;
`endif
    endfunction

    task automatic rand_lanes();
        for (int l = 0; l < 8; l++) lanes[l] = 8'($urandom_range(0, 255));
    endtask

    // Wait on negedges for done. Optionally raise in_valid for the first
    // cycle of the drain so that the DUT has to ignore it.
    task automatic wait_done(input bit drain_pulse, output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            if (drain_pulse && lat == 1) begin
                in_valid = 1'b1;
                rand_lanes();
            end else begin
                in_valid = 1'b0;
            end
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    // mode 0: all lanes = val, mode 1: random lanes, mode 2: in0 = val, others 0
    task automatic run_frame(input string tag, input int n, input int mode, input logic [7:0] val,
                             input bit drain_pulse, input bit done_pulse);
        int exp_sum = 0;
        int lat;
        bit seen;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            if (b == 1) begin
                check_val({tag, " start_sum_clr"}, 32'(sum), 0);
                check_val({tag, " start_ovf_clr"}, 32'(ovf), 0);
            end
            in_valid = 1'b1;
            for (int l = 0; l < 8; l++) begin
                if (mode == 0)      lanes[l] = val;
                else if (mode == 1) lanes[l] = 8'($urandom_range(0, 255));
                else                lanes[l] = (l == 0) ? val : 8'd0;
                if (b < MAX) exp_sum += int'(lanes[l]);
            end
        end
        @(negedge clk);
        if (n == 1) begin
            check_val({tag, " start_sum_clr"}, 32'(sum), 0);
            check_val({tag, " start_ovf_clr"}, 32'(ovf), 0);
        end
        in_valid = 1'b0;
        rand_lanes();
        wait_done(drain_pulse, lat, seen);
        check_val({tag, " done_seen"}, 32'(seen), 1);
        if (n <= MAX) check_val({tag, " done_lat"}, 32'(lat), 3);
        check_val({tag, " sum"}, 32'(sum), 32'(exp_sum));
        check_val({tag, " ovf"}, 32'(ovf), (n > MAX) ? 1 : 0);
        check_val({tag, " avg"}, 32'(avg), 32'(exp_avg(exp_sum)));
        if (done_pulse) begin
            // Beat offered during DONE must not start a frame
            in_valid = 1'b1;
            rand_lanes();
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_val({tag, " done_width"}, 32'(done), 0);
        repeat (3) @(negedge clk);
        check_val({tag, " sum_hold"}, 32'(sum), 32'(exp_sum));
        check_val({tag, " ovf_hold"}, 32'(ovf), (n > MAX) ? 1 : 0);
    endtask

    initial begin
        int lat;
        bit seen;
        int done_cnt;

        rst      = 1'b1;
        in_valid = 1'b0;
        for (int l = 0; l < 8; l++) lanes[l] = 8'd0;
        repeat (2) @(negedge clk);
        check_val("rst sum", 32'(sum), 0);
        check_val("rst done", 32'(done), 0);
        check_val("rst ovf", 32'(ovf), 0);
        check_val("rst avg", 32'(avg), 0);
        rst = 1'b0;

        run_frame("full_scale", 32, 0, 8'hFF, 1'b0, 1'b0);
        run_frame("ones", 32, 0, 8'h01, 1'b0, 1'b1);
        run_frame("half_round", 1, 2, 8'h80, 1'b0, 1'b0);
        run_frame("overflow", 34, 0, 8'h02, 1'b0, 1'b0);
        run_frame("b2b_a", 5, 0, 8'h10, 1'b1, 1'b0);
        run_frame("b2b_b", 3, 0, 8'h20, 1'b1, 1'b0);

        for (int f = 0; f < 16; f++) begin
            run_frame("rand", $urandom_range(1, 36), 1, 8'd0,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset asserted between edges in the middle of a frame
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            for (int l = 0; l < 8; l++) lanes[l] = 8'h05;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrst sum", 32'(sum), 0);
        check_val("midrst done", 32'(done), 0);
        check_val("midrst ovf", 32'(ovf), 0);
        check_val("midrst avg", 32'(avg), 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check_val("midrst no_done", 32'(done_cnt), 0);
        check_val("midrst sum_after", 32'(sum), 0);

        // A beat presented right at reset release is taken on the first edge
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        for (int l = 0; l < 8; l++) lanes[l] = 8'h03;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(1'b0, lat, seen);
        check_val("post_rst done_seen", 32'(seen), 1);
        check_val("post_rst done_lat", 32'(lat), 3);
        check_val("post_rst sum", 32'(sum), 24);
        @(negedge clk);
        check_val("post_rst done_width", 32'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tree_accumulator.md
TREE_ACCUMULATOR -- requirements
Module: tree_accumulator

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: beat qualifier; high means in0..in7 carry valid data this cycle.
REQ-004 SHALL have ports in0..in7, input, 8 bits each: eight unsigned samples per beat.
REQ-005 SHALL have port sum, output, 16 bits: unsigned frame total, registered.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse, sum final.
REQ-007 SHALL have port ovf, output, 1 bit: sticky flag, frame exceeded 32 beats.
REQ-008 SHALL have port avg, output, 8 bits: rounded mean, see Configuration.
REQ-009 SHALL have parameter MAX_BEATS, default 32: beats accepted per frame.

Function
REQ-010 SHALL implement states IDLE, FILL, DRAIN, DONE in a registered FSM.
REQ-011 IDLE: in_valid=1 SHALL clear sum, clear ovf, accept beat as beat 1, go to FILL.
REQ-012 FILL: each in_valid=1 beat SHALL be accepted while beat count < MAX_BEATS; a beat arriving at count = MAX_BEATS SHALL be dropped and set ovf.
REQ-013 FILL: in_valid=0 SHALL end the frame and go to DRAIN; frame ends only on in_valid low.
REQ-014 DRAIN: in_valid SHALL be ignored; stay until adder pipeline holds no valid beat, then go to DONE.
REQ-015 DONE: done=1 for exactly one cycle, then IDLE; in_valid in DONE SHALL be ignored.
REQ-016 Adder tree SHALL be three registered stages: 4 pair sums (9 bits), 2 sums (10 bits), 1 sum (11 bits), each tagged with a valid bit.
REQ-017 Accumulator SHALL add the 11-bit stage-3 result, zero-extended, into 16-bit sum when stage-3 valid is set.
REQ-018 Beat sampled at edge N SHALL reach sum at edge N+3; done SHALL rise at the same edge that the last beat reaches sum.
REQ-019 Full-scale frame (32 beats x 8 x 0xFF = 65280) SHALL fit 16 bits; no wrap SHALL occur for accepted beats.
REQ-020 Beat counter SHALL be 6 bits, reset to 0 at frame start, saturating at MAX_BEATS.
REQ-021 sum and ovf SHALL hold their values from DONE until the next frame start in IDLE.
REQ-022 in_valid high in the same cycle the FSM enters IDLE from DONE SHALL not be accepted until the FSM is in IDLE (one-cycle gap minimum between frames).

Reset
REQ-023 rst=1 SHALL asynchronously force FSM to IDLE, all stage registers and valid bits to 0, beat count 0, sum=0, done=0, ovf=0, avg=0.
REQ-024 Reset mid-frame SHALL discard all in-flight beats; no done pulse SHALL follow release.
REQ-025 First edge after rst release SHALL be able to accept a beat in IDLE.

Configuration
REQ-026 Macro TREE_ACC_AVG_EN defined: avg SHALL equal (sum + 128) >> 8 truncated to 8 bits, combinational from registered sum, computed in 17 bits without overflow.
REQ-027 Macro TREE_ACC_AVG_EN undefined: avg SHALL be constant 0 and no rounding adder SHALL be synthesized.

Verification
REQ-028 32 beats all lanes 0xFF, then in_valid low -> sum=65280, done one pulse 3 edges after last beat, avg=255 (AVG_EN), ovf=0.
REQ-029 32 beats all lanes 0x01 -> sum=256, avg=1; beats lanes 0x00 except in0=0x80 once -> sum=128, avg=1 (rounding up at half).
REQ-030 34 beats all lanes 0x02 -> sum=512 (beats 33-34 dropped), ovf=1 held through DONE and IDLE until next frame start.
REQ-031 rst asserted between edges at beat 10 of a frame -> sum=0, done=0 immediately; next 1-beat frame of 0x03 -> sum=24, done pulse.
REQ-032 Two back-to-back frames (5 beats 0x10, gap, 3 beats 0x20) with in_valid pulsed high during DRAIN -> sums 640 then 768; DRAIN pulse ignored; sum cleared at second frame start.
